// File: rtl/fm_discriminator_if.sv
// Avalon-ST style sample path between the I/Q source, the discriminator and the FIR sink.
// The source side drives the sink signals; the discriminator drives the result and the overrun flag.
interface fm_discriminator_if #(
   parameter int DATA_WIDTH = 16
) ();
   logic [DATA_WIDTH-1:0] ast_sink_i;
   logic [DATA_WIDTH-1:0] ast_sink_q;
   logic                  ast_sink_valid;
   logic [1:0]            ast_sink_error;
   logic [DATA_WIDTH-1:0] ast_source_data;
   logic                  ast_source_valid;
   logic [1:0]            ast_source_error;
   logic                  overrun;

   modport master (
      output ast_sink_i, ast_sink_q, ast_sink_valid, ast_sink_error,
      input  ast_source_data, ast_source_valid, ast_source_error, overrun
   );

   modport slave (
      input  ast_sink_i, ast_sink_q, ast_sink_valid, ast_sink_error,
      output ast_source_data, ast_source_valid, ast_source_error, overrun
   );
endinterface

// File: rtl/fm_discriminator.sv
// Polar FM discriminator: vectoring CORDIC phase, then wrapped phase difference; result ITER+1 cycles after accept.
// No backpressure: error-free samples arriving mid-rotation are dropped and latch the sticky overrun flag.
module fm_discriminator #(
   parameter int DATA_WIDTH = 16,
   parameter int ITER       = 14
) (
   input  logic                 clk,
   input  logic                 reset_n,
   fm_discriminator_if.slave    ast
);
   localparam int XW = DATA_WIDTH + 2;

   typedef enum logic [1:0] {IDLE = 2'd0, ROT = 2'd1, DONE = 2'd2} state_t;

   state_t                 state_q, state_d;
   logic signed [XW-1:0]   x_q, x_d, y_q, y_d;
   logic [15:0]            z_q, z_d, prev_q, prev_d;
   logic [3:0]             k_q, k_d;
   logic [DATA_WIDTH-1:0]  data_q, data_d;
   logic                   valid_q, valid_d, ovr_q, ovr_d;

   logic                   sample_ok, accept;
   logic signed [XW-1:0]   i_ext, q_ext;
   logic [15:0]            d_phase, lut;
   logic signed [DATA_WIDTH-1:0] d_ext;

   // atan(2^-k) in units of 65536 per turn
   function automatic logic [15:0] atan_lut(input logic [3:0] k);
      case (k)
         4'd0:  atan_lut = 16'd8192;
         4'd1:  atan_lut = 16'd4836;
         4'd2:  atan_lut = 16'd2555;
         4'd3:  atan_lut = 16'd1297;
         4'd4:  atan_lut = 16'd651;
         4'd5:  atan_lut = 16'd326;
         4'd6:  atan_lut = 16'd163;
         4'd7:  atan_lut = 16'd81;
         4'd8:  atan_lut = 16'd41;
         4'd9:  atan_lut = 16'd20;
         4'd10: atan_lut = 16'd10;
         4'd11: atan_lut = 16'd5;
         4'd12: atan_lut = 16'd3;
         4'd13: atan_lut = 16'd1;
         4'd14: atan_lut = 16'd1;
         default: atan_lut = 16'd0;
      endcase
   endfunction

   assign sample_ok = ast.ast_sink_valid && (ast.ast_sink_error == 2'b00);
   assign i_ext     = {{2{ast.ast_sink_i[DATA_WIDTH-1]}}, ast.ast_sink_i};
   assign q_ext     = {{2{ast.ast_sink_q[DATA_WIDTH-1]}}, ast.ast_sink_q};
   assign lut       = atan_lut(k_q);
   assign d_phase   = z_q - prev_q;
   assign d_ext     = DATA_WIDTH'($signed(d_phase));

   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      z_d     = z_q;
      k_d     = k_q;
      prev_d  = prev_q;
      data_d  = data_q;
      valid_d = 1'b0;
      ovr_d   = ovr_q;
      accept  = 1'b0;

      case (state_q)
         IDLE: accept = sample_ok;
         ROT: begin
            if (sample_ok) ovr_d = 1'b1;
            if (!y_q[XW-1]) begin
               x_d = x_q + (y_q >>> k_q);
               y_d = y_q - (x_q >>> k_q);
               z_d = z_q + lut;
            end else begin
               x_d = x_q - (y_q >>> k_q);
               y_d = y_q + (x_q >>> k_q);
               z_d = z_q - lut;
            end
            k_d = k_q + 4'd1;
            if (k_q == 4'(ITER - 1)) state_d = DONE;
         end
         DONE: begin
            data_d  = d_ext << (DATA_WIDTH - 16);
            valid_d = 1'b1;
            prev_d  = z_q;
            state_d = IDLE;
            accept  = sample_ok;
         end
         default: state_d = IDLE;
      endcase

      // Left half-plane inputs are rotated by pi so the CORDIC only sees |angle| <= pi/2
      if (accept) begin
         state_d = ROT;
         k_d     = 4'd0;
         if (ast.ast_sink_i[DATA_WIDTH-1]) begin
            x_d = -i_ext;
            y_d = -q_ext;
            z_d = 16'h8000;
         end else begin
            x_d = i_ext;
            y_d = q_ext;
            z_d = 16'h0000;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= IDLE;
         x_q     <= '0;
         y_q     <= '0;
         z_q     <= '0;
         k_q     <= '0;
         prev_q  <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         z_q     <= z_d;
         k_q     <= k_d;
         prev_q  <= prev_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         ovr_q   <= ovr_d;
      end
   end

   assign ast.ast_source_data  = data_q;
   assign ast.ast_source_valid = valid_q;
   assign ast.ast_source_error = 2'b00;
   assign ast.overrun          = ovr_q;
endmodule

// File: tb/tb_fm_discriminator.sv
// Bench for fm_discriminator: random and directed I/Q stimulus, ideal atan2 reference, queued scoreboard.
module tb_fm_discriminator;
   localparam int DW   = 16;
   localparam int ITER = 14;
   localparam real PI  = 3.14159265358979;

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   fm_discriminator_if #(.DATA_WIDTH(DW)) ast ();
   fm_discriminator #(.DATA_WIDTH(DW), .ITER(ITER)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .ast     (ast)
   );

   typedef struct {
      int exp;
      int tol;
      int cyc;
   } exp_t;

   exp_t sbq[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   edge_n = 0;
   int   prev_ph = 0;
   int   last_acc = -1000;
   bit   ov_m = 1'b0;
   bit   fresh = 1'b1;

   always @(posedge clk) edge_n++;

   function automatic int wrap16(int v);
      int r;
      r = v % 65536;
      if (r < 0) r += 65536;
      if (r >= 32768) r -= 65536;
      return r;
   endfunction

   function automatic int ideal_phase(int i, int q);
      real a;
      a = $atan2(real'(q), real'(i));
      return wrap16(int'(a * 32768.0 / PI));
   endfunction

   task automatic check(string name, int act, int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Scoreboard monitor: every result pulse must match the oldest outstanding expectation
   always @(negedge clk) begin
      exp_t e;
      int   act, derr;
      if (ast.ast_source_valid === 1'b1) begin
         if (sbq.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_valid: got result %0d at edge %0d, expected no output",
                     $signed(ast.ast_source_data), edge_n);
         end else begin
            e    = sbq.pop_front();
            act  = $signed(ast.ast_source_data) >>> (DW - 16);
            derr = wrap16(act - e.exp);
            n_cmp++;
            if (derr > e.tol || derr < -e.tol) begin
               n_bad++;
               $display("FAIL phase_diff: got %0d, expected %0d +/- %0d", act, e.exp, e.tol);
            end
            check("result_edge", edge_n, e.cyc);
            check("source_error", int'(ast.ast_source_error), 0);
         end
      end
   end

   task automatic idle(int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send(int i, int q, logic [1:0] err);
      int ph;
      ast.ast_sink_i     = DW'(i);
      ast.ast_sink_q     = DW'(q);
      ast.ast_sink_error = err;
      ast.ast_sink_valid = 1'b1;
      @(posedge clk);
      #1;
      ast.ast_sink_valid = 1'b0;
      ast.ast_sink_error = 2'b00;
      if (err == 2'b00) begin
         if (edge_n - last_acc >= ITER + 1) begin
            ph = ideal_phase(i, q);
            sbq.push_back('{exp: wrap16(ph - prev_ph), tol: (fresh ? 4 : 8), cyc: edge_n + ITER + 1});
            prev_ph  = ph;
            last_acc = edge_n;
            fresh    = 1'b0;
         end else begin
            ov_m = 1'b1;
         end
      end
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      @(posedge clk);
      #1;
      reset_n  = 1'b1;
      sbq.delete();
      prev_ph  = 0;
      last_acc = -1000;
      ov_m     = 1'b0;
      fresh    = 1'b1;
   endtask

   task automatic drain();
      int guard;
      guard = 0;
      while (sbq.size() != 0 && guard < 200) begin
         @(posedge clk);
         #1;
         guard++;
      end
      check("drain_pending", sbq.size(), 0);
      idle(2);
   endtask

   task automatic phasor(int amp, real step, int n);
      for (int s = 0; s < n; s++) begin
         send(int'(amp * $cos(step * s)), int'(amp * $sin(step * s)), 2'b00);
         idle(15);
      end
      drain();
   endtask

   initial begin
      int  amp;
      real ang;
      reset_n            = 1'b0;
      ast.ast_sink_i     = '0;
      ast.ast_sink_q     = '0;
      ast.ast_sink_valid = 1'b0;
      ast.ast_sink_error = 2'b00;
      repeat (3) @(posedge clk);
      #1;
      reset_n = 1'b1;
      idle(1);

      check("reset_data", int'(ast.ast_source_data), 0);
      check("reset_valid", int'(ast.ast_source_valid), 0);
      check("reset_overrun", int'(ast.overrun), 0);

      // Constant carrier: zero frequency offset
      for (int s = 0; s < 6; s++) begin
         send(16000, 0, 2'b00);
         idle(15);
      end
      drain();

      phasor(16000, PI / 4.0, 16);
      phasor(16000, -PI / 4.0, 16);
      phasor(16000, 3.0 * PI / 4.0, 16);

      // Random tones with spacing down to ITER+1 (accept on the DONE cycle) and bad-sample strobes
      for (int s = 0; s < 40; s++) begin
         amp = $urandom_range(4000, 30000);
         ang = real'($urandom_range(0, 65535)) * 2.0 * PI / 65536.0;
         send(int'(amp * $cos(ang)), int'(amp * $sin(ang)),
              ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00);
         idle($urandom_range(ITER, ITER + 4));
      end
      drain();
      check("overrun_after_random", int'(ast.overrun), int'(ov_m));

      // Full-scale edge inputs, each as a first result so it reports absolute phase
      do_reset();
      send(-32768, 0, 2'b00);
      drain();
      do_reset();
      send(0, -32768, 2'b00);
      drain();

      // Flagged sample is silently discarded
      do_reset();
      send(16000, 0, 2'b01);
      idle(20);
      check("error_no_overrun", int'(ast.overrun), 0);
      check("error_no_pending", sbq.size(), 0);

      // Second sample three cycles after the first is an overrun
      send(12000, 9000, 2'b00);
      idle(2);
      send(-5000, 14000, 2'b00);
      check("overrun_set", int'(ast.overrun), int'(ov_m));
      drain();
      check("overrun_sticky", int'(ast.overrun), 1);

      // Reset lands on iteration 5: in-flight sample vanishes, history and overrun clear
      do_reset();
      send(-9000, 11000, 2'b00);
      idle(5);
      do_reset();
      check("midreset_overrun", int'(ast.overrun), 0);
      idle(20);
      send(7000, -13000, 2'b00);
      drain();

      check("final_queue_empty", sbq.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
